// File: rtl/instrn_server.sv
// -----------------------------------------------------------------------------
// instrn_server
//   Instruction-supply and result-collection partner of the RISC core.
//   The host loads a program into local memory. While running, the server
//   returns one instruction per cycle, indexed by the core's PC. Every result
//   word the core qualifies with OUT_VALID is queued for the host to read out.
//
// Ports
//   Clk, Reset                 rising-edge clock; asynchronous active-low reset
//   Load_Start/Valid/Data/Done host program-load handshake (Load_Ready out)
//   Run_Start, Run_Stop, Clear host run control
//   PC, Rd_Instr -> Instrn     core fetch interface (one-cycle latency)
//   RESULT_DATA, OUT_VALID     core result stream into the FIFO
//   STACK_FULL                 core fault flag (only acted on in RUN)
//   Res_Valid/Data/Ready       show-ahead result FIFO readout
//   Res_Ovf, Core_Fault, Done  sticky status / halted indication
//   Prog_Len, Fetch_Cnt        loaded word count, fetches in current run
// -----------------------------------------------------------------------------
module instrn_server #(
  parameter int          PROG_DEPTH = 256,
  parameter int          RES_DEPTH  = 16,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Load_Start,
  input  logic        Load_Valid,
  input  logic [31:0] Load_Data,
  output logic        Load_Ready,
  input  logic        Load_Done,
  input  logic        Run_Start,
  input  logic        Run_Stop,
  input  logic        Clear,
  input  logic [7:0]  PC,
  input  logic        Rd_Instr,
  output logic [31:0] Instrn,
  input  logic [15:0] RESULT_DATA,
  input  logic        OUT_VALID,
  input  logic        STACK_FULL,
  output logic        Res_Valid,
  output logic [15:0] Res_Data,
  input  logic        Res_Ready,
  output logic        Res_Ovf,
  output logic        Core_Fault,
  output logic        Done,
  output logic [8:0]  Prog_Len,
  output logic [15:0] Fetch_Cnt
);

  localparam int             PAW        = $clog2(PROG_DEPTH);
  localparam int             RAW        = $clog2(RES_DEPTH);
  localparam logic [8:0]     L_LAST_WR  = 9'(PROG_DEPTH - 1);
  localparam logic [RAW:0]   L_RES_FULL = (RAW + 1)'(RES_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_t;

  state_t r_state, w_state_nxt;

  // program store (not reset)
  logic [31:0] r_prog_mem [PROG_DEPTH];
  logic [8:0]  r_prog_len;   // doubles as the load write pointer
  logic [31:0] r_instrn;
  logic [15:0] r_fetch_cnt;
  logic        r_core_fault;
  logic        r_res_ovf;

  // result FIFO
  logic [15:0]    r_res_mem [RES_DEPTH];
  logic [RAW-1:0] r_rp, r_wp;
  logic [RAW:0]   r_cnt;

  logic w_load_wr, w_load_last, w_in_range, w_halt, w_clear;
  logic w_full, w_pop, w_push, w_drop;

  assign w_load_wr   = (r_state == S_LOAD) && Load_Valid;
  assign w_load_last = w_load_wr && (r_prog_len == L_LAST_WR);
  assign w_in_range  = {1'b0, PC} < r_prog_len;
  // any halt reason seen this cycle while running
  assign w_halt      = (r_state == S_RUN) &&
                       ((Rd_Instr && !w_in_range) || Run_Stop || STACK_FULL);
  assign w_clear     = (r_state == S_HALT) && Clear;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    Load_Ready  = 1'b0;
    Done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Load_Start)                          w_state_nxt = S_LOAD;
        else if (Run_Start && r_prog_len != '0)  w_state_nxt = S_RUN;
      end
      S_LOAD: begin
        Load_Ready = 1'b1;
        // the word accepted alongside Load_Done is still written
        if (Load_Done || w_load_last) w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (w_halt) w_state_nxt = S_HALT;
      end
      S_HALT: begin
        Done = 1'b1;
        if (Clear) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Program load and fetch
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (w_load_wr) r_prog_mem[r_prog_len[PAW-1:0]] <= Load_Data;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_prog_len   <= '0;
      r_instrn     <= NOP_INSTR;
      r_fetch_cnt  <= '0;
      r_core_fault <= 1'b0;
    end else begin
      if (r_state == S_IDLE && Load_Start) r_prog_len <= '0;
      else if (w_load_wr)                  r_prog_len <= r_prog_len + 9'd1;

      // Halting cycle already returns NOP so HALT never shows a stale word.
      if (r_state == S_RUN && !w_halt && w_in_range)
        r_instrn <= r_prog_mem[PC[PAW-1:0]];
      else
        r_instrn <= NOP_INSTR;

      if (r_state == S_IDLE && w_state_nxt == S_RUN) r_fetch_cnt <= '0;
      else if (r_state == S_RUN && Rd_Instr)         r_fetch_cnt <= r_fetch_cnt + 16'd1;

      if (r_state == S_RUN && STACK_FULL) r_core_fault <= 1'b1;
      else if (w_clear)                   r_core_fault <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO (runs in every state)
  // ---------------------------------------------------------------------------
  assign w_full = (r_cnt == L_RES_FULL);
  assign w_pop  = Res_Valid && Res_Ready;
  // a pop in the same cycle frees the slot for a push into a full FIFO
  assign w_push = OUT_VALID && (!w_full || w_pop);
  assign w_drop = OUT_VALID && w_full && !w_pop;

  always_ff @(posedge Clk) begin
    if (w_push) r_res_mem[r_wp] <= RESULT_DATA;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_rp      <= '0;
      r_wp      <= '0;
      r_cnt     <= '0;
      r_res_ovf <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      // a fresh drop outranks a simultaneous Clear
      if (w_drop)       r_res_ovf <= 1'b1;
      else if (w_clear) r_res_ovf <= 1'b0;
    end
  end

  assign Res_Valid  = (r_cnt != '0);
  assign Res_Data   = Res_Valid ? r_res_mem[r_rp] : 16'h0000;
  assign Res_Ovf    = r_res_ovf;
  assign Core_Fault = r_core_fault;
  assign Instrn     = r_instrn;
  assign Prog_Len   = r_prog_len;
  assign Fetch_Cnt  = r_fetch_cnt;

endmodule
